// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver and scancode-to-Hack keycode translator.
// Samples the raw PS/2 clock/data lines and deframes 11-bit frames. It then tracks
// the E0 (extended) and F0 (break) prefixes and drives the Hack keycode of
// the held key.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd
// parity. Without it the parity bit is consumed and ignored.
module ps2_keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_strobe,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Synchronizers and falling-edge detector
    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic ps2_data_meta_q, ps2_data_sync_q;
    logic ps2_fall;

    // Frame receiver state
    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_error_q, frame_error_d;
    logic            stop_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic            parity_q, parity_d;
`endif

    // Byte processor state
    logic [7:0]      keycode_q, keycode_d;
    logic            key_strobe_q, key_strobe_d;
    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic [7:0]      hack_code;

    // Map a scancode (with its extended prefix) to the Hack keycode, 0 if unmapped.
    function automatic logic [7:0] translate(input logic [7:0] sc, input logic ext);
        logic [7:0] code;
        code = 8'd0;
        if (ext) begin
            case (sc)
                8'h6B:   code = 8'd130;  // left
                8'h75:   code = 8'd131;  // up
                8'h74:   code = 8'd132;  // right
                8'h72:   code = 8'd133;  // down
                default: code = 8'd0;
            endcase
        end else begin
            case (sc)
                8'h1C: code = 8'd65;  8'h32: code = 8'd66;  8'h21: code = 8'd67;
                8'h23: code = 8'd68;  8'h24: code = 8'd69;  8'h2B: code = 8'd70;
                8'h34: code = 8'd71;  8'h33: code = 8'd72;  8'h43: code = 8'd73;
                8'h3B: code = 8'd74;  8'h42: code = 8'd75;  8'h4B: code = 8'd76;
                8'h3A: code = 8'd77;  8'h31: code = 8'd78;  8'h44: code = 8'd79;
                8'h4D: code = 8'd80;  8'h15: code = 8'd81;  8'h2D: code = 8'd82;
                8'h1B: code = 8'd83;  8'h2C: code = 8'd84;  8'h3C: code = 8'd85;
                8'h2A: code = 8'd86;  8'h1D: code = 8'd87;  8'h22: code = 8'd88;
                8'h35: code = 8'd89;  8'h1A: code = 8'd90;
                8'h45: code = 8'd48;  8'h16: code = 8'd49;  8'h1E: code = 8'd50;
                8'h26: code = 8'd51;  8'h25: code = 8'd52;  8'h2E: code = 8'd53;
                8'h36: code = 8'd54;  8'h3D: code = 8'd55;  8'h3E: code = 8'd56;
                8'h46: code = 8'd57;
                8'h29: code = 8'd32;   // space
                8'h5A: code = 8'd128;  // enter
                8'h66: code = 8'd129;  // backspace
                8'h76: code = 8'd140;  // escape
                default: code = 8'd0;
            endcase
        end
        return code;
    endfunction

    // Bring the asynchronous PS/2 lines into the clk domain and keep the previous clock level.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset_n) begin
            // NOTE: synchronizers reset to 1 (idle bus) so leaving reset never fakes a falling edge.
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q;

`ifdef PS2_PARITY_CHECK_EN
    assign stop_ok = ps2_data_sync_q & (^{shift_q, parity_q});
`else
    assign stop_ok = ps2_data_sync_q;
`endif

    // Frame FSM next state: deframe on falling edges, abandon a partial frame on timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        to_cnt_d      = to_cnt_q;
        rx_byte_d     = rx_byte_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d      = parity_q;
`endif
        if (ps2_fall) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!ps2_data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {ps2_data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = ps2_data_sync_q;
`endif
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (stop_ok) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shift_q;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                state_d       = ST_IDLE;
                bit_cnt_d     = 3'd0;
                shift_d       = 8'd0;
                to_cnt_d      = '0;
                frame_error_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // Frame FSM registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            to_cnt_q      <= '0;
            rx_byte_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            to_cnt_q      <= to_cnt_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign hack_code = translate(rx_byte_q, ext_q);

    // Byte processor: track prefixes, then apply make/break of a scancode to the held keycode.
    always_comb begin
        keycode_d    = keycode_q;
        key_strobe_d = 1'b0;
        ext_d        = ext_q;
        brk_d        = brk_q;
        if (rx_valid_q) begin
            case (rx_byte_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (hack_code != 8'd0) begin
                        if (brk_q) begin
                            if (hack_code == keycode_q) begin
                                keycode_d = 8'd0;
                            end
                        end else begin
                            keycode_d    = hack_code;
                            key_strobe_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Byte processor registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            keycode_q    <= 8'd0;
            key_strobe_q <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            keycode_q    <= keycode_d;
            key_strobe_q <= key_strobe_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
        end
    end

    assign keycode     = keycode_q;
    assign key_strobe  = key_strobe_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Self-checking bench for ps2_keyboard_decoder: directed scenarios plus random
// frames checked by a scoreboard against a table-driven keyboard model.
module tb_ps2_keyboard_decoder;

    localparam int TO       = 150;  // timeout used for the DUT instance
    localparam int HALF     = 4;    // clk cycles per PS/2 clock half period
    localparam int GAP      = 12;   // idle clk cycles after each frame
    localparam int SYNC_LAT = 3;    // two sync flops plus the edge register

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_strobe;
    logic       frame_error;

    ps2_keyboard_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keycode    (keycode),
        .key_strobe (key_strobe),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fall_cyc   = 0;
    int last_strobe_cyc = 0;

    always @(posedge clk) cyc++;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
    } ev_t;
    ev_t sb[$];

    // Reference model state
    int         norm_map[256];
    int         ext_map[256];
    logic [7:0] m_kc;
    bit         m_ext, m_brk;

    logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] arrows[4]   = '{8'h6B, 8'h75, 8'h74, 8'h72};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void build_tables();
        for (int i = 0; i < 256; i++) begin
            norm_map[i] = 0;
            ext_map[i]  = 0;
        end
        for (int i = 0; i < 26; i++) norm_map[letters[i]] = 65 + i;
        for (int i = 0; i < 10; i++) norm_map[digits[i]] = 48 + i;
        norm_map[8'h29] = 32;
        norm_map[8'h5A] = 128;
        norm_map[8'h66] = 129;
        norm_map[8'h76] = 140;
        for (int i = 0; i < 4; i++) ext_map[arrows[i]] = 130 + i;
    endfunction

    function automatic void model_reset();
        m_kc  = 8'd0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    // Keyboard-level meaning of one accepted byte.
    function automatic void model_byte(input logic [7:0] b);
        int code;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            code = m_ext ? ext_map[b] : norm_map[b];
            if (code != 0) begin
                if (m_brk) begin
                    if (code == int'(m_kc)) m_kc = 8'd0;
                end else begin
                    m_kc = 8'(code);
                    sb.push_back('{is_err: 1'b0, code: 8'(code)});
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        bit rejected;
        rejected = stop_bad;
`ifdef PS2_PARITY_CHECK_EN
        rejected = rejected | par_bad;
`endif
        if (rejected) sb.push_back('{is_err: 1'b1, code: 8'd0});
        else model_byte(b);
    endfunction

    // One PS/2 bit: data changes while the clock is high, device drives a low pulse.
    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        logic par;
        par = (~^b) ^ par_bad;
        model_frame(b, par_bad, stop_bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(~stop_bad);
        repeat (GAP) @(negedge clk);
        check("keycode_after_frame", int'(keycode), int'(m_kc));
    endtask

    // Monitor: every output event must match the next scoreboard entry.
    always @(negedge clk) begin
        ev_t e;
        if (key_strobe || frame_error) begin
            if (key_strobe) last_strobe_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_event", int'({key_strobe, frame_error}), 0);
            end else begin
                e = sb.pop_front();
                check("event_kind", int'({key_strobe, frame_error}), e.is_err ? 1 : 2);
                if (!e.is_err) check("strobe_keycode", int'(keycode), int'(e.code));
            end
        end
    end

    // Watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_cyc;
        logic [7:0] last_make;
        logic [7:0] b;

        build_tables();
        model_reset();

        // Reset state
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_keycode", int'(keycode), 0);
        check("reset_strobe", int'(key_strobe), 0);
        check("reset_frame_error", int'(frame_error), 0);

        // Single make and its latency from the stop-bit edge
        send_frame(8'h1C, 1'b0, 1'b0);
        check("make_latency", last_strobe_cyc - last_fall_cyc, SYNC_LAT + 1);

        // Break of the held key
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);

        // Extended make, last key wins, break of a non-held key
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);

        // Bad stop bit, then bad parity
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b0);

        // Timeout after four data bits, then a clean frame
        sb.push_back('{is_err: 1'b1, code: 8'd0});
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        err_cyc = -1;
        for (int i = 0; i < 2 * TO + 20; i++) begin
            @(negedge clk);
            if (frame_error) begin
                err_cyc = cyc;
                break;
            end
        end
        check("timeout_latency", err_cyc - last_fall_cyc, TO + SYNC_LAT);
        repeat (GAP) @(negedge clk);
        send_frame(8'h45, 1'b0, 1'b0);

        // Reset mid-frame after a make: remaining bits of 0xF0 are all ones
        send_frame(8'h1C, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        check("midframe_reset_keycode", int'(keycode), 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        send_bit(1'b1);  // parity of 0xF0
        send_bit(1'b1);  // stop
        repeat (GAP) @(negedge clk);
        check("after_reset_keycode", int'(keycode), 0);

        // Random traffic
        last_make = 8'h1C;
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    if ($urandom_range(0, 1) == 0) b = letters[$urandom_range(0, 25)];
                    else b = digits[$urandom_range(0, 9)];
                    last_make = b;
                    send_frame(b, 1'b0, 1'b0);
                end
                3: begin
                    b = ($urandom_range(0, 1) == 0) ? last_make : letters[$urandom_range(0, 25)];
                    send_frame(8'hF0, 1'b0, 1'b0);
                    send_frame(b, 1'b0, 1'b0);
                end
                4: begin
                    send_frame(8'hE0, 1'b0, 1'b0);
                    send_frame(arrows[$urandom_range(0, 3)], 1'b0, 1'b0);
                end
                5: begin
                    send_frame(8'hE0, 1'b0, 1'b0);
                    send_frame(8'hF0, 1'b0, 1'b0);
                    send_frame(arrows[$urandom_range(0, 3)], 1'b0, 1'b0);
                end
                6: send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
                7: begin
                    b = arrows[$urandom_range(0, 3)];
                    send_frame(b, 1'b0, 1'b0);  // keypad code without prefix
                end
                8: send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
                default: send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            endcase
        end

        repeat (20) @(negedge clk);
        check("pending_events", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
